// File: rtl/fpu_pkg.sv
// Shared RV32F sequencing definitions: op codes, FSM states, flag layout and
// IEEE-754 single-precision class helpers.
package fpu_pkg;

  localparam logic [2:0] OpFadd    = 3'd0;
  localparam logic [2:0] OpFsub    = 3'd1;
  localparam logic [2:0] OpFmul    = 3'd2;
  localparam logic [2:0] OpFdiv    = 3'd3;
  localparam logic [2:0] OpFsgnj   = 3'd4;
  localparam logic [2:0] OpFsgnjn  = 3'd5;
  localparam logic [2:0] OpFsgnjx  = 3'd6;
  localparam logic [2:0] OpIllegal = 3'd7;

  localparam logic [31:0] CanonNan = 32'h7fc00000;

  // Flag vector layout {NV,DZ,OF,UF,NX}
  localparam int FlagNv = 4;
  localparam int FlagDz = 3;
  localparam int FlagOf = 2;
  localparam int FlagUf = 1;
  localparam int FlagNx = 0;

  typedef enum logic [1:0] {StIdle, StLaunch, StWait, StResp} seq_state_e;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] != 23'd0);
  endfunction

  function automatic logic is_inf(input logic [31:0] x);
    return (x[30:23] == 8'hff) && (x[22:0] == 23'd0);
  endfunction

  function automatic logic is_zero(input logic [31:0] x);
    return x[30:0] == 31'd0;
  endfunction

  // Magnitude of a, sign chosen by the sign-injection variant.
  function automatic logic [31:0] sign_inject(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
    logic sign;
    case (op)
      OpFsgnj:  sign = b[31];
      OpFsgnjn: sign = ~b[31];
      default:  sign = a[31] ^ b[31];
    endcase
    return {sign, a[30:0]};
  endfunction

endpackage

// File: rtl/fpu_issue_seq_if.sv
// Decode request, FP unit start/done and writeback signals of the FP issue sequencer.
interface fpu_issue_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] unit_a;
  logic [31:0] unit_b;
  logic        add_start;
  logic        mul_start;
  logic        div_start;
  logic        add_done;
  logic        mul_done;
  logic        div_done;
  logic [31:0] add_result;
  logic [31:0] mul_result;
  logic [31:0] div_result;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [4:0]  wb_flags;
  logic        err;

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_rd, req_a, req_b,
    input  add_done, mul_done, div_done, add_result, mul_result, div_result,
    input  wb_ready,
    output req_ready, unit_a, unit_b, add_start, mul_start, div_start,
    output wb_valid, wb_rd, wb_data, wb_flags, err
  );

  // Decode / unit / writeback side
  modport master (
    output req_valid, req_op, req_rd, req_a, req_b,
    output add_done, mul_done, div_done, add_result, mul_result, div_result,
    output wb_ready,
    input  req_ready, unit_a, unit_b, add_start, mul_start, div_start,
    input  wb_valid, wb_rd, wb_data, wb_flags, err
  );
endinterface

// File: rtl/fpu_flag_classify.sv
// Combinational IEEE exception flag classification of an FP result against its operands.
module fpu_flag_classify
  import fpu_pkg::*;
(
  input  logic [31:0] r,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [4:0]  flags
);

  logic a_special;
  logic b_special;
  logic div_zero;

  always_comb begin
    a_special = is_inf(a) | is_nan(a);
    b_special = is_inf(b) | is_nan(b);
    div_zero  = (op == OpFdiv) && is_zero(b) && !is_zero(a) && !a_special;

    flags         = '0;
    flags[FlagNv] = is_nan(r);
    flags[FlagDz] = div_zero;
    flags[FlagOf] = is_inf(r) && !a_special && !b_special && !div_zero;
    flags[FlagUf] = 1'b0;
    flags[FlagNx] = 1'b0;
    // Sign injection is exact and never raises anything
    if (op >= OpFsgnj && op <= OpFsgnjx) begin
      flags = '0;
    end
  end

endmodule

// File: rtl/fpu_issue_seq.sv
// Issue sequencer between RV32F decode and the multi-cycle add/mul/div units; sign
// injection is executed locally, illegal ops and unit timeouts return a canonical NaN.
module fpu_issue_seq
  import fpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input logic            clk,
  input logic            rst,
  fpu_issue_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [4:0]       FlagsNv    = 5'b1 << FlagNv;

  seq_state_e       state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      unit_a_q, unit_a_d;
  logic [31:0]      unit_b_q, unit_b_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic [4:0]       wb_flags_q, wb_flags_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        sel_done;
  logic [31:0] sel_result;
  logic [4:0]  unit_flags;

  // Only the unit that was launched is listened to
  always_comb begin
    sel_done   = 1'b0;
    sel_result = '0;
    case (op_q)
      OpFadd, OpFsub: begin
        sel_done   = bus.add_done;
        sel_result = bus.add_result;
      end
      OpFmul: begin
        sel_done   = bus.mul_done;
        sel_result = bus.mul_result;
      end
      OpFdiv: begin
        sel_done   = bus.div_done;
        sel_result = bus.div_result;
      end
      default: ;
    endcase
  end

  fpu_flag_classify u_classify (
    .r     (sel_result),
    .a     (unit_a_q),
    .b     (unit_b_q),
    .op    (op_q),
    .flags (unit_flags)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    unit_a_d   = unit_a_q;
    unit_b_d   = unit_b_q;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_flags_d = wb_flags_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          op_d     = bus.req_op;
          wb_rd_d  = bus.req_rd;
          unit_a_d = bus.req_a;
          unit_b_d = {bus.req_b[31] ^ (bus.req_op == OpFsub), bus.req_b[30:0]};
          if (bus.req_op <= OpFdiv) begin
            state_d = StLaunch;
          end else if (bus.req_op == OpIllegal) begin
            wb_data_d  = CanonNan;
            wb_flags_d = FlagsNv;
            err_d      = 1'b1;
            state_d    = StResp;
          end else begin
            wb_data_d  = sign_inject(bus.req_op, bus.req_a, bus.req_b);
            wb_flags_d = '0;
            state_d    = StResp;
          end
        end
      end
      StLaunch: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sel_done) begin
          wb_data_d  = sel_result;
          wb_flags_d = unit_flags;
          state_d    = StResp;
        end else if (cnt_d == TimeoutCnt) begin
          wb_data_d  = CanonNan;
          wb_flags_d = FlagsNv;
          err_d      = 1'b1;
          state_d    = StResp;
        end
      end
      StResp: begin
        if (bus.wb_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpFadd;
      unit_a_q   <= '0;
      unit_b_q   <= '0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_flags_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      unit_a_q   <= unit_a_d;
      unit_b_q   <= unit_b_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_flags_q <= wb_flags_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.add_start = (state_q == StLaunch) && (op_q == OpFadd || op_q == OpFsub);
  assign bus.mul_start = (state_q == StLaunch) && (op_q == OpFmul);
  assign bus.div_start = (state_q == StLaunch) && (op_q == OpFdiv);
  assign bus.wb_valid  = (state_q == StResp);
  assign bus.unit_a    = unit_a_q;
  assign bus.unit_b    = unit_b_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_flags  = wb_flags_q;
  assign bus.err       = err_q;

endmodule
